get_length_param: RTL and testbench

- Parametrised bit-length finder for RSA operands. It returns the position of the most-significant 1 plus one (1001b -> 4), and 0 for a zero operand.
- Successor to the fixed 64-bit, 1-bit-per-cycle length unit. Adds generic WIDTH, STEP bits examined per cycle, and an early-exit MSB-first mode.
- Feeds the exponent length to the RL binary exponentiation controller, which uses it as the loop bound.

---
 rtl/get_length_param.sv | 147 ++++++++++++++
 tb/tb_get_length_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/get_length_param.sv
// Bit-length finder for RSA operands: returns MSB position + 1, or 0 for a zero operand.
// Latency: mode 0 = N+1 edges from the accepting edge; mode 1 = j+2 edges (first nonzero chunk j), N+1 if zero.
// Backpressure: none; md_start is ignored while busy (not queued); outputs are held until the next result.
// Optional build macro GET_LENGTH_POPCOUNT_EN: adds ones_out (popcount) and forces a full scan in both modes.
module get_length_param #(
  parameter int  WIDTH = 64,
  parameter int  STEP  = 1,
  localparam int N     = WIDTH / STEP,
  localparam int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             md_start,
  input  logic             mode,
  input  logic [WIDTH-1:0] num_in,
  output logic [LW-1:0]    len_out,
  output logic             zero_out,
  output logic             busy,
  output logic             md_end
`ifdef GET_LENGTH_POPCOUNT_EN
  ,
  output logic [LW-1:0]    ones_out
`endif
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] op_q;
  logic             mode_q;
  logic [KW-1:0]    k;
  logic [LW-1:0]    len_w, len_n;
  logic [LW-1:0]    base, lo, msb, cand;
  logic [WIDTH-1:0] shifted;
  logic [STEP-1:0]  chunk;
  logic             nz, last;
`ifdef GET_LENGTH_POPCOUNT_EN
  logic [LW-1:0]    ones_w, ones_n, ones_c;
`endif

  // Chunk selection and per-chunk length candidate (shared by both scan directions).
  always_comb begin
    base    = LW'(k) * LW'(STEP);
    // Mode 1 walks from the top: chunk j starts at bit WIDTH-STEP-j*STEP.
    lo      = mode_q ? (LW'(WIDTH - STEP) - base) : base;
    shifted = op_q >> lo;
    chunk   = shifted[STEP-1:0];
    nz      = |chunk;
    msb     = '0;
    for (int i = 0; i < STEP; i++) begin
      if (chunk[i]) msb = LW'(i);
    end
    cand    = lo + msb + LW'(1);
    last    = (k == KW'(N - 1));
`ifdef GET_LENGTH_POPCOUNT_EN
    ones_c  = '0;
    for (int i = 0; i < STEP; i++) begin
      ones_c = ones_c + LW'(chunk[i]);
    end
`endif
  end

  // Next-state and next working values.
  always_comb begin
    state_n = state;
    len_n   = len_w;
`ifdef GET_LENGTH_POPCOUNT_EN
    ones_n  = ones_w;
`endif
    case (state)
      IDLE: begin
        if (md_start) state_n = SCAN;
      end
      SCAN: begin
`ifdef GET_LENGTH_POPCOUNT_EN
        // Full scan always; in mode 1 only the first nonzero chunk sets the length.
        if (nz && (!mode_q || len_w == '0)) len_n = cand;
        ones_n = ones_w + ones_c;
        if (last) state_n = DONE;
`else
        // Mode 0: later chunks override. Mode 1: first hit is final and exits.
        if (nz) len_n = cand;
        if (last || (nz && mode_q)) state_n = DONE;
`endif
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      md_end   <= 1'b0;
      len_out  <= '0;
      zero_out <= 1'b0;
`ifdef GET_LENGTH_POPCOUNT_EN
      ones_out <= '0;
`endif
    end else begin
      state  <= state_n;
      busy   <= (state_n != IDLE);
      md_end <= (state_n == DONE);
      if (state == SCAN && state_n == DONE) begin
        len_out  <= len_n;
        zero_out <= (len_n == '0);
`ifdef GET_LENGTH_POPCOUNT_EN
        ones_out <= ones_n;
`endif
      end
    end
  end

  // Operand capture on the accepting edge and working registers during the scan.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_q   <= '0;
      mode_q <= 1'b0;
      k      <= '0;
      len_w  <= '0;
`ifdef GET_LENGTH_POPCOUNT_EN
      ones_w <= '0;
`endif
    end else if (state == IDLE && md_start) begin
      op_q   <= num_in;
      mode_q <= mode;
      k      <= '0;
      len_w  <= '0;
`ifdef GET_LENGTH_POPCOUNT_EN
      ones_w <= '0;
`endif
    end else if (state == SCAN) begin
      k      <= k + KW'(1);
      len_w  <= len_n;
`ifdef GET_LENGTH_POPCOUNT_EN
      ones_w <= ones_n;
`endif
    end
  end

endmodule

// File: tb/tb_get_length_param.sv
// Directed bench for get_length_param: STEP=1 and STEP=4 instances (plus STEP=8 when popcount is built).
// Checks reset state, latency in both modes, lengths incl. WIDTH, zero operand, abort and back-to-back starts.
// Expected values are hand-computed constants.
module tb_get_length_param;

  localparam int WIDTH = 64;
  localparam int LW    = 7;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] num_in = '0;
  logic             start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;

  logic [LW-1:0] len1, len4, len_s;
  logic          zero1, zero4, zero_s;
  logic          busy1, busy4, busy_s;
  logic          end1, end4, end_s;
`ifdef GET_LENGTH_POPCOUNT_EN
  logic [LW-1:0] ones1, ones4, ones8;
  logic [LW-1:0] len8;
  logic          zero8, busy8, end8;
`endif

  int tests = 0;
  int fails = 0;
  int cur_sel = 1;

  always #5 clk = ~clk;

  get_length_param #(.WIDTH(WIDTH), .STEP(1)) u1 (
    .clk(clk), .rstn(rstn), .md_start(start1), .mode(mode), .num_in(num_in),
    .len_out(len1), .zero_out(zero1), .busy(busy1), .md_end(end1)
`ifdef GET_LENGTH_POPCOUNT_EN
    , .ones_out(ones1)
`endif
  );

  get_length_param #(.WIDTH(WIDTH), .STEP(4)) u4 (
    .clk(clk), .rstn(rstn), .md_start(start4), .mode(mode), .num_in(num_in),
    .len_out(len4), .zero_out(zero4), .busy(busy4), .md_end(end4)
`ifdef GET_LENGTH_POPCOUNT_EN
    , .ones_out(ones4)
`endif
  );

`ifdef GET_LENGTH_POPCOUNT_EN
  get_length_param #(.WIDTH(WIDTH), .STEP(8)) u8 (
    .clk(clk), .rstn(rstn), .md_start(start8), .mode(mode), .num_in(num_in),
    .len_out(len8), .zero_out(zero8), .busy(busy8), .md_end(end8), .ones_out(ones8)
  );
`endif

  always_comb begin
    len_s = len1; zero_s = zero1; busy_s = busy1; end_s = end1;
    if (cur_sel == 4) begin
      len_s = len4; zero_s = zero4; busy_s = busy4; end_s = end4;
    end
`ifdef GET_LENGTH_POPCOUNT_EN
    if (cur_sel == 8) begin
      len_s = len8; zero_s = zero8; busy_s = busy8; end_s = end8;
    end
`endif
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v;
    else if (sel == 4) start4 = v;
    else start8 = v;
  endtask

  // Mode-1 latency: early exit at j+2, or full N+1 when popcount forces a full scan.
  function automatic int m1_edges(input int n, input int j);
`ifdef GET_LENGTH_POPCOUNT_EN
    return n + 1 + 0 * j;
`else
    return j + 2 + 0 * n;
`endif
  endfunction

  // One job: pulse start, scramble inputs after capture, count edges to md_end.
  task automatic run(input string tag, input int sel, input logic [63:0] num, input logic md,
                     input int exp_edges, input int exp_len);
    int edges;
    bit seen;
    cur_sel = sel;
    @(negedge clk);
    num_in = num;
    mode   = md;
    set_start(sel, 1'b1);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        set_start(sel, 1'b0);
        num_in = ~num;
        mode   = ~md;
        check({tag, " busy"}, busy_s, 1);
      end
      if (end_s) seen = 1'b1;
    end
    check({tag, " latency"}, edges, exp_edges);
    check({tag, " len"}, len_s, exp_len);
    check({tag, " zero"}, zero_s, (exp_len == 0) ? 1 : 0);
    @(posedge clk);
    #1;
    check({tag, " end pulse"}, end_s, 0);
    check({tag, " idle"}, busy_s, 0);
  endtask

  initial begin
    int e, first, second;
    bit bad_end, bad_busy;

    repeat (3) @(posedge clk);
    #1;
    cur_sel = 1;
    check("rst len", len1, 0);
    check("rst zero", zero1, 0);
    check("rst busy", busy1, 0);
    check("rst end", end1, 0);
    @(negedge clk);
    rstn = 1'b1;

    run("s1 m0 0x9", 1, 64'h9, 1'b0, 65, 4);
    run("s1 m0 zero", 1, 64'h0, 1'b0, 65, 0);
    run("s1 m1 zero", 1, 64'h0, 1'b1, 65, 0);
    run("s1 m1 top", 1, 64'h8000_0000_0000_0000, 1'b1, m1_edges(64, 0), 64);
    run("s1 m1 lsb", 1, 64'h1, 1'b1, m1_edges(64, 63), 1);
    run("s4 m1 0x10000", 4, 64'h1_0000, 1'b1, m1_edges(16, 11), 17);
    run("s4 m0 0x10000", 4, 64'h1_0000, 1'b0, 17, 17);
    run("s4 m1 0x3", 4, 64'h3, 1'b1, m1_edges(16, 15), 2);
    run("s1 m0 top", 1, 64'h8000_0000_0000_0000, 1'b0, 65, 64);

    // Abort: second start while busy is ignored, reset at edge 20 kills the job.
    cur_sel = 1;
    @(negedge clk);
    num_in = 64'hFF;
    mode   = 1'b0;
    start1 = 1'b1;
    bad_end  = 1'b0;
    bad_busy = 1'b0;
    for (e = 1; e <= 19; e++) begin
      @(posedge clk);
      #1;
      if (end1) bad_end = 1'b1;
      if (!busy1) bad_busy = 1'b1;
      if (e == 1) start1 = 1'b0;
      if (e == 9) begin start1 = 1'b1; num_in = 64'h1; end
      if (e == 10) start1 = 1'b0;
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("abort no end", bad_end, 0);
    check("abort busy held", bad_busy, 0);
    check("abort busy", busy1, 0);
    check("abort end", end1, 0);
    check("abort len", len1, 0);
    check("abort zero", zero1, 0);
    @(negedge clk);
    rstn = 1'b1;
    bad_end = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (end1 || busy1) bad_end = 1'b1;
    end
    check("abort quiet", bad_end, 0);
    run("s1 fresh 0x1", 1, 64'h1, 1'b0, 65, 1);

    // Back-to-back: start held high through DONE is taken on the first IDLE edge.
    cur_sel = 4;
    @(negedge clk);
    num_in = 64'h1_0000;
    mode   = 1'b0;
    start4 = 1'b1;
    e = 0; first = 0; second = 0;
    while (second == 0 && e < 100) begin
      @(posedge clk);
      #1;
      e++;
      if (end4) begin
        if (first == 0) first = e;
        else second = e;
      end
    end
    start4 = 1'b0;
    check("b2b first", first, 17);
    check("b2b second", second, 35);
    check("b2b len", len4, 17);
    repeat (20) @(posedge clk);

`ifdef GET_LENGTH_POPCOUNT_EN
    run("s8 pop", 8, 64'hF0F0_0000_0000_0001, 1'b1, 9, 64);
    check("s8 ones", ones8, 9);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
